registra_tiro_multi: RTL and testbench
======================================

REGISTRA_TIRO_MULTI -- requirements
Module: registra_tiro_multi

Interface
REQ-001 Parameter MAX_TIROS, default 8, number of shot slots, SHALL be a power of two, min 2.
REQ-002 Parameter POS_W, default 10, coordinate width.
REQ-003 Parameter DIR_W, default 3, direction width.
REQ-004 Parameter COOLDOWN_CICLOS, default 16, cooldown length in cycles, min 1.
REQ-005 Port: clock  in  1  single system clock; all state changes on the rising edge.
REQ-006 Port: reset  in  1  asynchronous, active-low reset.
REQ-007 Port: registra_tiro  in  1  fire request, level, held by requester until released.
REQ-008 Port: nave_x, nave_y  in  POS_W  ship position.
REQ-009 Port: nave_dir  in  DIR_W  ship direction.
REQ-010 Port: slot_ocupado  in  MAX_TIROS  live occupancy vector, bit i = slot i in use.
REQ-011 Port: we_tiro  out  1  one-cycle shot-memory write strobe.
REQ-012 Port: addr_tiro  out  log2(MAX_TIROS)  slot being written.
REQ-013 Port: tiro_x, tiro_y  out  POS_W; tiro_dir  out  DIR_W  latched shot record.
REQ-014 Port: tiro_registrado  out  1  shot stored; tiro_negado  out  1  no free slot.
REQ-015 Port: ocupado  out  1  high in every state except ESPERA.
REQ-016 Port: db_estado_registra_tiro  out  4  current state code.

Function
REQ-017 FSM states and codes: INICIAL=0, ESPERA=1, CAPTURA=2, BUSCA=3, GRAVA=4, REGISTRADO=5, NEGADO=6, COOLDOWN=7.
REQ-018 INICIAL -> ESPERA unconditionally after one cycle.
REQ-019 ESPERA: registra_tiro=1 -> CAPTURA; else stay.
REQ-020 CAPTURA: latch nave_x/nave_y/nave_dir into tiro_x/tiro_y/tiro_dir; load scan index idx <= ptr and scan count <= 0; -> BUSCA.
REQ-021 BUSCA, one slot per cycle: if slot_ocupado[idx]=0 -> GRAVA with idx held.
REQ-022 BUSCA, slot occupied and count < MAX_TIROS-1: idx <= (idx+1) mod MAX_TIROS, count++, stay in BUSCA.
REQ-023 BUSCA, slot occupied and count = MAX_TIROS-1 -> NEGADO; every slot has then been checked exactly once.
REQ-024 GRAVA: we_tiro=1 for exactly this cycle, addr_tiro=idx; ptr <= (idx+1) mod MAX_TIROS (wrap from MAX_TIROS-1 to 0); -> REGISTRADO.
REQ-025 REGISTRADO: tiro_registrado=1 while in the state; leave only when registra_tiro=0. Next state is set by REQ-030/REQ-031.
REQ-026 NEGADO: tiro_negado=1 while in the state; -> ESPERA when registra_tiro=0; no write, ptr unchanged.
REQ-027 Latency, first slot free: request seen at edge k gives we_tiro high in cycle k+3 and tiro_registrado from k+4.
REQ-028 Worst-case search: MAX_TIROS cycles in BUSCA.
REQ-029 slot_ocupado is sampled live each BUSCA cycle; changes during a search take effect immediately. Record outputs hold their value until the next CAPTURA.

Reset
REQ-030 reset=0 SHALL force, asynchronously:
- state INICIAL, ptr=0, idx=0, count=0, cooldown counter=0;
- we_tiro=0, tiro_registrado=0, tiro_negado=0, addr_tiro=0;
- tiro_x=0, tiro_y=0, tiro_dir=0, ocupado=1, db=0.
Reset mid-search or mid-write SHALL abort with no further write strobe.

Configuration
REQ-031 Macro REGISTRA_TIRO_COOLDOWN_EN defined:
- REGISTRADO with registra_tiro=0 -> COOLDOWN;
- COOLDOWN lasts exactly COOLDOWN_CICLOS cycles, ignores registra_tiro, then -> ESPERA.
Macro undefined: REGISTRADO -> ESPERA directly, code 7 unreachable, no cooldown counter synthesised.

Verification
REQ-032 MAX_TIROS=4, slot_ocupado=0000, request with x=100, y=50, dir=3, release after 6 cycles -> one we_tiro at addr 0, record 100/50/3, tiro_registrado until release, ptr=1.
REQ-033 slot_ocupado=0011, ptr=0, request -> BUSCA for 3 cycles, single write at addr 2.
REQ-034 slot_ocupado=1111 -> 4 BUSCA cycles, NEGADO, tiro_negado=1, no we_tiro, return to ESPERA on release.
REQ-035 ptr=3, slot 3 free -> write at addr 3, ptr wraps to 0; next request writes addr 0.
REQ-036 reset=0 asserted during BUSCA -> immediate INICIAL, all outputs at reset values, no write.
REQ-037 With macro, COOLDOWN_CICLOS=4, request held through cooldown -> state 7 for 4 cycles, then new CAPTURA.

Source files
------------

// File: rtl/registra_tiro_multi_if.sv
// Shot-register request/record bus: the requester (master) drives ship state and slot occupancy,
// and the registrar (slave) returns the write strobe, the latched shot record and the status flags.
interface registra_tiro_multi_if #(
   parameter int unsigned MAX_TIROS = 8,
   parameter int unsigned POS_W     = 10,
   parameter int unsigned DIR_W     = 3
);
   localparam int unsigned AW = $clog2(MAX_TIROS);

   logic                 registra_tiro;
   logic [POS_W-1:0]     nave_x;
   logic [POS_W-1:0]     nave_y;
   logic [DIR_W-1:0]     nave_dir;
   logic [MAX_TIROS-1:0] slot_ocupado;
   logic                 we_tiro;
   logic [AW-1:0]        addr_tiro;
   logic [POS_W-1:0]     tiro_x;
   logic [POS_W-1:0]     tiro_y;
   logic [DIR_W-1:0]     tiro_dir;
   logic                 tiro_registrado;
   logic                 tiro_negado;
   logic                 ocupado;
   logic [3:0]           db_estado_registra_tiro;

   modport slave (
      input  registra_tiro, nave_x, nave_y, nave_dir, slot_ocupado,
      output we_tiro, addr_tiro, tiro_x, tiro_y, tiro_dir, tiro_registrado, tiro_negado,
             ocupado, db_estado_registra_tiro
   );

   modport master (
      output registra_tiro, nave_x, nave_y, nave_dir, slot_ocupado,
      input  we_tiro, addr_tiro, tiro_x, tiro_y, tiro_dir, tiro_registrado, tiro_negado,
             ocupado, db_estado_registra_tiro
   );
endinterface

// File: rtl/registra_tiro_multi.sv
// Shot registrar: captures the ship state, searches for a free slot starting at a rotating pointer
// and writes the shot there. Define REGISTRA_TIRO_COOLDOWN_EN to add a post-shot cooldown state.
module registra_tiro_multi #(
   parameter int unsigned MAX_TIROS       = 8,
   parameter int unsigned POS_W           = 10,
   parameter int unsigned DIR_W           = 3,
   parameter int unsigned COOLDOWN_CICLOS = 16
) (
   input logic                    clock,
   input logic                    reset,
   registra_tiro_multi_if.slave   bus
);
   localparam int unsigned AW = $clog2(MAX_TIROS);

   if (MAX_TIROS < 2 || (MAX_TIROS & (MAX_TIROS - 1)) != 0) begin : g_bad_max_tiros
      $error("MAX_TIROS must be a power of two, at least 2");
   end
   if (COOLDOWN_CICLOS < 1) begin : g_bad_cooldown
      $error("COOLDOWN_CICLOS must be at least 1");
   end

   typedef enum logic [3:0] {
      StInicial    = 4'd0,
      StEspera     = 4'd1,
      StCaptura    = 4'd2,
      StBusca      = 4'd3,
      StGrava      = 4'd4,
      StRegistrado = 4'd5,
      StNegado     = 4'd6,
      StCooldown   = 4'd7
   } estado_t;

   estado_t          estado_q;
   logic [AW-1:0]    ptr_q;
   logic [AW-1:0]    idx_q;
   logic [AW-1:0]    cnt_q;
   logic             we_q;
   logic [AW-1:0]    addr_q;
   logic [POS_W-1:0] x_q;
   logic [POS_W-1:0] y_q;
   logic [DIR_W-1:0] dir_q;
   logic             registrado_q;
   logic             negado_q;
   logic             ocupado_q;

`ifdef REGISTRA_TIRO_COOLDOWN_EN
   localparam int unsigned CW = (COOLDOWN_CICLOS > 1) ? $clog2(COOLDOWN_CICLOS) : 1;
   logic [CW-1:0] cd_q;
`endif

   // Flag outputs are registered alongside the next state so they line up with the state code.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         estado_q     <= StInicial;
         ptr_q        <= '0;
         idx_q        <= '0;
         cnt_q        <= '0;
         we_q         <= 1'b0;
         addr_q       <= '0;
         x_q          <= '0;
         y_q          <= '0;
         dir_q        <= '0;
         registrado_q <= 1'b0;
         negado_q     <= 1'b0;
         ocupado_q    <= 1'b1;
`ifdef REGISTRA_TIRO_COOLDOWN_EN
         cd_q         <= '0;
`endif
      end else begin
         we_q         <= 1'b0;
         registrado_q <= 1'b0;
         negado_q     <= 1'b0;
         ocupado_q    <= 1'b1;
         unique case (estado_q)
            StInicial: begin
               estado_q  <= StEspera;
               ocupado_q <= 1'b0;
            end
            StEspera: begin
               if (bus.registra_tiro) estado_q <= StCaptura;
               else                   ocupado_q <= 1'b0;
            end
            StCaptura: begin
               x_q      <= bus.nave_x;
               y_q      <= bus.nave_y;
               dir_q    <= bus.nave_dir;
               idx_q    <= ptr_q;
               cnt_q    <= '0;
               estado_q <= StBusca;
            end
            StBusca: begin
               if (!bus.slot_ocupado[idx_q]) begin
                  estado_q <= StGrava;
                  we_q     <= 1'b1;
                  addr_q   <= idx_q;
               end else if (cnt_q == AW'(MAX_TIROS - 1)) begin
                  estado_q <= StNegado;
                  negado_q <= 1'b1;
               end else begin
                  idx_q <= idx_q + 1'b1;
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            StGrava: begin
               ptr_q        <= idx_q + 1'b1;
               estado_q     <= StRegistrado;
               registrado_q <= 1'b1;
            end
            StRegistrado: begin
               if (bus.registra_tiro) begin
                  registrado_q <= 1'b1;
               end else begin
`ifdef REGISTRA_TIRO_COOLDOWN_EN
                  estado_q <= StCooldown;
                  cd_q     <= '0;
`else
                  estado_q  <= StEspera;
                  ocupado_q <= 1'b0;
`endif
               end
            end
            StNegado: begin
               if (bus.registra_tiro) begin
                  negado_q <= 1'b1;
               end else begin
                  estado_q  <= StEspera;
                  ocupado_q <= 1'b0;
               end
            end
            StCooldown: begin
`ifdef REGISTRA_TIRO_COOLDOWN_EN
               if (cd_q == CW'(COOLDOWN_CICLOS - 1)) begin
                  estado_q  <= StEspera;
                  ocupado_q <= 1'b0;
               end else begin
                  cd_q <= cd_q + 1'b1;
               end
`else
               estado_q  <= StEspera;
               ocupado_q <= 1'b0;
`endif
            end
            default: estado_q <= StInicial;
         endcase
      end
   end

   assign bus.we_tiro                 = we_q;
   assign bus.addr_tiro               = addr_q;
   assign bus.tiro_x                  = x_q;
   assign bus.tiro_y                  = y_q;
   assign bus.tiro_dir                = dir_q;
   assign bus.tiro_registrado         = registrado_q;
   assign bus.tiro_negado             = negado_q;
   assign bus.ocupado                 = ocupado_q;
   assign bus.db_estado_registra_tiro = estado_q;

endmodule

// File: tb/tb_registra_tiro_multi.sv
// Directed bench for registra_tiro_multi with four slots: a vector table of shot requests plus
// hand sequences for latency, reset during search and (when enabled) the cooldown window.
module tb_registra_tiro_multi;
   logic clock = 1'b0;
   logic reset = 1'b0;
   int   n_vec = 0;
   int   n_err = 0;

   always #5 clock = ~clock;

   registra_tiro_multi_if #(.MAX_TIROS(4), .POS_W(10), .DIR_W(3)) bus ();

   registra_tiro_multi #(
      .MAX_TIROS(4), .POS_W(10), .DIR_W(3), .COOLDOWN_CICLOS(4)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus)
   );

   typedef struct {
      bit         rst;
      logic [3:0] slots;
      logic [9:0] x;
      logic [9:0] y;
      logic [2:0] dir;
      int         hold;
      bit         exp_reg;
      int         exp_addr;
      int         exp_busca;
   } vec_t;

   vec_t vecs[7];

   task automatic check(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic do_reset();
      reset = 1'b0;
      bus.registra_tiro = 1'b0;
      repeat (2) @(negedge clock);
      reset = 1'b1;
   endtask

   task automatic run_vec(input int n, input vec_t v);
      int busca_n = 0;
      int we_n    = 0;
      int waddr   = -1;
      bit done    = 1'b0;
      if (v.rst) do_reset();
      @(negedge clock);
      bus.slot_ocupado  = v.slots;
      bus.nave_x        = v.x;
      bus.nave_y        = v.y;
      bus.nave_dir      = v.dir;
      bus.registra_tiro = 1'b1;
      for (int c = 0; c < 20 && !done; c++) begin
         @(negedge clock);
         if (bus.db_estado_registra_tiro == 4'd3) busca_n++;
         if (bus.we_tiro) begin
            we_n++;
            waddr = int'(bus.addr_tiro);
         end
         if (bus.tiro_registrado || bus.tiro_negado) done = 1'b1;
      end
      check($sformatf("v%0d finish", n), int'(done), 1);
      check($sformatf("v%0d registrado", n), int'(bus.tiro_registrado), int'(v.exp_reg));
      check($sformatf("v%0d negado", n), int'(bus.tiro_negado), int'(!v.exp_reg));
      check($sformatf("v%0d busca cycles", n), busca_n, v.exp_busca);
      if (v.exp_reg) check($sformatf("v%0d addr", n), waddr, v.exp_addr);
      check($sformatf("v%0d tiro_x", n), int'(bus.tiro_x), int'(v.x));
      check($sformatf("v%0d tiro_y", n), int'(bus.tiro_y), int'(v.y));
      check($sformatf("v%0d tiro_dir", n), int'(bus.tiro_dir), int'(v.dir));
      for (int h = 0; h < v.hold; h++) begin
         @(negedge clock);
         if (bus.we_tiro) we_n++;
      end
      check($sformatf("v%0d flag held", n),
            int'(v.exp_reg ? bus.tiro_registrado : bus.tiro_negado), 1);
      bus.registra_tiro = 1'b0;
      done = 1'b0;
      for (int c = 0; c < 30 && !done; c++) begin
         @(negedge clock);
         if (bus.we_tiro) we_n++;
         if (bus.db_estado_registra_tiro == 4'd1) done = 1'b1;
      end
      check($sformatf("v%0d back to espera", n), int'(done), 1);
      check($sformatf("v%0d ocupado idle", n), int'(bus.ocupado), 0);
      check($sformatf("v%0d write count", n), we_n, v.exp_reg ? 1 : 0);
   endtask

   initial begin
      bit seen;
      int we_n;
      int cd_n;

      // rst slots x y dir hold reg addr busca
      vecs[0] = '{1'b1, 4'b0000, 10'd100, 10'd50, 3'd3, 6, 1'b1, 0, 1};
      vecs[1] = '{1'b1, 4'b0011, 10'd5, 10'd6, 3'd1, 2, 1'b1, 2, 3};
      vecs[2] = '{1'b0, 4'b0111, 10'd1023, 10'd0, 3'd7, 1, 1'b1, 3, 1};
      vecs[3] = '{1'b0, 4'b0000, 10'd9, 10'd9, 3'd0, 1, 1'b1, 0, 1};
      vecs[4] = '{1'b0, 4'b1111, 10'd200, 10'd300, 3'd5, 3, 1'b0, 0, 4};
      vecs[5] = '{1'b0, 4'b1011, 10'd11, 10'd22, 3'd2, 0, 1'b1, 2, 2};
      vecs[6] = '{1'b0, 4'b1110, 10'd33, 10'd44, 3'd6, 1, 1'b1, 0, 2};

      bus.registra_tiro = 1'b0;
      bus.nave_x        = '0;
      bus.nave_y        = '0;
      bus.nave_dir      = '0;
      bus.slot_ocupado  = '0;

      // Reset values and first-request latency.
      repeat (2) @(negedge clock);
      check("rst state", int'(bus.db_estado_registra_tiro), 0);
      check("rst ocupado", int'(bus.ocupado), 1);
      check("rst we", int'(bus.we_tiro), 0);
      check("rst flags", int'({bus.tiro_registrado, bus.tiro_negado}), 0);
      check("rst record", int'({bus.tiro_x, bus.tiro_y, bus.tiro_dir, bus.addr_tiro}), 0);
      reset = 1'b1;
      @(negedge clock);
      check("inicial->espera", int'(bus.db_estado_registra_tiro), 1);
      check("espera ocupado", int'(bus.ocupado), 0);
      bus.nave_x = 10'd321; bus.nave_y = 10'd123; bus.nave_dir = 3'd4;
      bus.registra_tiro = 1'b1;
      @(negedge clock);
      check("lat captura", int'(bus.db_estado_registra_tiro), 2);
      check("lat ocupado", int'(bus.ocupado), 1);
      @(negedge clock);
      check("lat busca", int'(bus.db_estado_registra_tiro), 3);
      check("lat no early we", int'(bus.we_tiro), 0);
      @(negedge clock);
      check("lat we", int'(bus.we_tiro), 1);
      check("lat grava", int'(bus.db_estado_registra_tiro), 4);
      @(negedge clock);
      check("lat we one cycle", int'(bus.we_tiro), 0);
      check("lat registrado", int'(bus.tiro_registrado), 1);
      bus.registra_tiro = 1'b0;

      for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

      // Reset asserted in the middle of a search.
      do_reset();
      @(negedge clock);
      bus.slot_ocupado = 4'b1111; bus.nave_x = 10'd77; bus.registra_tiro = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 10 && !seen; c++) begin
         @(negedge clock);
         if (bus.db_estado_registra_tiro == 4'd3) seen = 1'b1;
      end
      check("mid busca reached", int'(seen), 1);
      #2 reset = 1'b0;
      #1;
      check("abort state", int'(bus.db_estado_registra_tiro), 0);
      check("abort ocupado", int'(bus.ocupado), 1);
      check("abort tiro_x", int'(bus.tiro_x), 0);
      check("abort flags", int'({bus.we_tiro, bus.tiro_registrado, bus.tiro_negado}), 0);
      bus.slot_ocupado = 4'b0000;
      we_n = 0;
      repeat (3) begin
         @(negedge clock);
         if (bus.we_tiro) we_n++;
      end
      check("abort no write", we_n, 0);
      bus.registra_tiro = 1'b0;
      reset = 1'b1;
      @(negedge clock);
      check("abort recover", int'(bus.db_estado_registra_tiro), 1);

      // Release after a stored shot, then request again.
      @(negedge clock);
      bus.registra_tiro = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 10 && !seen; c++) begin
         @(negedge clock);
         if (bus.tiro_registrado) seen = 1'b1;
      end
      check("pre-cooldown shot", int'(seen), 1);
      bus.registra_tiro = 1'b0;
      @(negedge clock);
      bus.registra_tiro = 1'b1;
`ifdef REGISTRA_TIRO_COOLDOWN_EN
      cd_n = 0;
      for (int c = 0; c < 10 && bus.db_estado_registra_tiro == 4'd7; c++) begin
         cd_n++;
         @(negedge clock);
      end
      check("cooldown cycles", cd_n, 4);
      check("cooldown->espera", int'(bus.db_estado_registra_tiro), 1);
`else
      cd_n = 0;
      check("direct espera", int'(bus.db_estado_registra_tiro), 1);
`endif
      @(negedge clock);
      check("new captura", int'(bus.db_estado_registra_tiro), 2);
      bus.registra_tiro = 1'b0;
      repeat (8) @(negedge clock);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
